hilo_ctrl: RTL

- Sequences every write to the 64-bit HI/LO register.
- Accepts MULT/MULTU, DIV/DIVU and MTHI/MTLO from the EX stage and runs a registered multiply or a 32-iteration restoring divide.
- Stalls the pipeline while an operation is in flight, then issues one write-enable/data pair to the HI/LO register.
- Sits between the EX-stage decode/ALU operands and the HI/LO register.

---
 rtl/hilo_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hilo_ctrl.sv
// HI/LO write sequencer: MT* writes pass straight through, MULT*/DIV* run a
// registered multiply or a 32-step restoring divide and then issue one write.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting; MT* written directly, MULT*/DIV* accepted here
// MUL    | latched operands multiplied into the result register
// DIV    | one restoring shift-subtract step per cycle
// DONE   | result register driven to HI/LO with write enable
module hilo_ctrl #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [63:0] hilo,
    input  logic        flush,
    output logic        stall_o,
    output logic        hilo_we,
    output logic [63:0] hilo_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]  state;
    logic [31:0] a_lat;
    logic [31:0] b_lat;
    logic        mul_signed;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [4:0]  cnt;
    logic [63:0] res;

    logic        is_mul;
    logic        is_div;
    logic        accept;
    logic        div_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [63:0] prod;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        step_ok;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic        last_step;

    assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign accept     = (state == S_IDLE) && op_valid && !flush;
    assign div_signed = (op == OP_DIV);

    assign a_abs = (div_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign b_abs = (div_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

    assign prod = mul_signed ? ({{32{a_lat[31]}}, a_lat} * {{32{b_lat[31]}}, b_lat})
                             : ({32'd0, a_lat} * {32'd0, b_lat});

    // Partial remainder stays below the divisor, so 33 bits hold the shifted value.
    assign rem_sh    = {rem, quo[31]};
    assign diff      = rem_sh - {1'b0, dvs};
    assign step_ok   = !diff[32];
    assign rem_nx    = step_ok ? diff[31:0] : rem_sh[31:0];
    assign quo_nx    = {quo[30:0], step_ok};
    assign q_fix     = q_neg ? (~quo_nx + 32'd1) : quo_nx;
    assign r_fix     = r_neg ? (~rem_nx + 32'd1) : rem_nx;
    assign last_step = (cnt == 5'(DIV_ITERS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            a_lat      <= '0;
            b_lat      <= '0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            dvs        <= '0;
            quo        <= '0;
            rem        <= '0;
            cnt        <= '0;
            res        <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        a_lat      <= src_a;
                        b_lat      <= src_b;
                        mul_signed <= (op == OP_MULT);
                        state      <= S_MUL;
                    end else if (accept && is_div) begin
                        a_lat <= src_a;
                        b_lat <= src_b;
                        quo   <= a_abs;
                        dvs   <= b_abs;
                        rem   <= '0;
                        cnt   <= '0;
                        q_neg <= div_signed && (src_a[31] ^ src_b[31]);
                        r_neg <= div_signed && src_a[31];
                        state <= S_DIV;
                    end
                end
                S_MUL: begin
                    res   <= prod;
                    state <= S_DONE;
                end
                S_DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 5'd1;
                    if (last_step) begin
                        // Divide by zero still burns the full iteration count.
                        res   <= (dvs == 32'd0) ? {a_lat, 32'hFFFF_FFFF} : {r_fix, q_fix};
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        hilo_we = 1'b0;
        hilo_o  = '0;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if (op_valid && !flush) begin
                        stall_o = is_mul || is_div;
                        if (op == OP_MTHI) begin
                            hilo_we = 1'b1;
                            hilo_o  = {src_a, hilo[31:0]};
                        end else if (op == OP_MTLO) begin
                            hilo_we = 1'b1;
                            hilo_o  = {hilo[63:32], src_a};
                        end
                    end
                end
                S_MUL, S_DIV: stall_o = 1'b1;
                default: begin
                    hilo_we = !flush;
                    hilo_o  = res;
                end
            endcase
        end
    end

    logic unused_b;
    assign unused_b = ^b_lat[31:0] & 1'b0;

endmodule
